serial_adder: RTL and testbench

//   Bit-serial N-bit adder with valid/ready handshakes on both sides. Accepts one
//   {a, b, cin} operand set and resolves one bit per clock, LSB first, through a

---
 rtl/serial_adder.sv | 139 +++++++++++++
 tb/tb_serial_adder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one registered full-adder slice resolves one bit per clock,
// LSB first. Valid/ready handshakes on both operand and result sides.
module serial_adder #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout
);

  // Counter must reach N-1 without wrapping; $clog2(N+1) also covers the N == 1 case.
  localparam int unsigned CntW    = $clog2(N + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAdd  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    a_sr_q, a_sr_d;
  logic [N-1:0]    b_sr_q, b_sr_d;
  logic [N-1:0]    sum_sr_q, sum_sr_d;
  logic            c_q, c_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;

  logic bit_s;
  logic bit_c;

  // Handshake outputs are decoded from state only, so no input-to-output comb path.
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;

  // Single full-adder slice operating on the current LSBs and the running carry.
  always_comb begin
    bit_s = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
    bit_c = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & c_q) | (b_sr_q[0] & c_q);
  end

  // Next-state logic: load on accept, shift one bit per ADD cycle, hold in DONE.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          a_sr_d   = a;
          b_sr_d   = b;
          sum_sr_d = '0;
          c_d      = cin;
          cnt_d    = '0;
          state_d  = StAdd;
        end
      end

      StAdd: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        // Shift-then-insert keeps this legal for N == 1 (no [N-1:1] slice).
        sum_sr_d         = sum_sr_q >> 1;
        sum_sr_d[N-1]    = bit_s;
        c_d              = bit_c;
        cnt_d            = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          // Publish the fully filled shift register and the final carry together.
          sum_d   = sum_sr_d;
          cout_d  = bit_c;
          state_d = StDone;
        end
      end

      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  // A stalled result must stay presented and unchanged.
  a_hold_result : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(sum) && $stable(cout)));

  // Accepting and presenting are mutually exclusive phases.
  a_phase_excl : assert property (@(posedge clk) disable iff (!rst_n)
    !(in_ready && out_valid));

  // The bit counter never runs past the last bit position.
  a_cnt_range : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StAdd) |-> (cnt_q <= LastCnt));

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: driver pushes a + b + cin, monitor pops on each result.
module tb_serial_adder;

  localparam int N = 4;

  typedef struct {
    logic [N:0] res;
    int         acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;

  int   tests  = 0;
  int   failed = 0;
  int   cyc    = 0;
  bit   rand_bp = 1'b0;
  exp_t exp_q[$];

  serial_adder #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Random consumer backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: runs after the driver's updates each cycle.
  initial begin
    logic prev_ov;
    exp_t e;
    prev_ov = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        prev_ov = 1'b0;
      end else begin
        check("in_ready_vs_busy", 32'(in_ready), 32'(exp_q.size() == 0));
        if (out_valid && exp_q.size() == 0) begin
          check("spurious_out_valid", 32'(out_valid), 32'd0);
        end
        if (out_valid && !prev_ov && exp_q.size() != 0) begin
          check("latency", 32'(cyc - exp_q[0].acc), 32'(N));
        end
        if (out_valid && out_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("result", 32'({cout, sum}), 32'(e.res));
        end
        prev_ov = out_valid;
      end
    end
  end

  // Offer one operand set (caller is just after a rising edge) and record its expectation.
  task automatic send(input logic [N-1:0] av, input logic [N-1:0] bv, input logic cv);
    int   guard;
    exp_t e;
    guard    = 0;
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    cin      = cv;
    forever begin
      @(negedge clk);
      if (in_ready || guard > 100) break;
      guard++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    e.res = {1'b0, av} + {1'b0, bv} + {{N{1'b0}}, cv};
    e.acc = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = N'($urandom);
    b        = N'($urandom);
    cin      = 1'($urandom);
  endtask

  // Scribble on the operand inputs while the adder is busy.
  task automatic churn(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      a   = N'($urandom);
      b   = N'($urandom);
      cin = 1'($urandom);
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(posedge clk);
      #3;
      guard++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed single operation: 1011 + 0110 + 1 = 1_0010
    send(4'b1011, 4'b0110, 1'b1);
    wait_drain();
    check("single_sum", 32'(sum), 32'h2);
    check("single_cout", 32'(cout), 32'h1);

    // Exhaustive operand sweep with the consumer always ready
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      send(v[3:0], v[7:4], v[8]);
    end
    wait_drain();

    // Random operands under random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 150; i++) begin
      send(N'($urandom), N'($urandom), 1'($urandom));
    end
    wait_drain();
    rand_bp = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Stalled consumer: result held, no new accept
    out_ready = 1'b0;
    send(4'hF, 4'h0, 1'b1);
    begin
      int guard;
      guard = 0;
      while (!out_valid && guard < 50) begin
        @(negedge clk);
        guard++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_sum", 32'(sum), 32'h0);
      check("bp_cout", 32'(cout), 32'h1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();
    @(negedge clk);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of an addition
    @(posedge clk);
    #1;
    send(4'h9, 4'h9, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < N + 4; i++) begin
      @(negedge clk);
      check("midrst_no_result", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Operand inputs churn while busy; only handshake values count
    for (int i = 0; i < 20; i++) begin
      send(N'($urandom), N'($urandom), 1'($urandom));
      churn(N + 1);
    end
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
